// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage interface.
// Accepts word loads/stores, completes them after LATENCY cycles and holds the pipeline with stall meanwhile.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY) + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx_q;
    logic [31:0]   data_q;
    logic          store_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [IW-1:0] idx;
    logic          req;
    logic          bad;
    logic          accept;
    logic          commit;
    logic          unused_addr_hi;

    // Upper address bits alias onto the array.
    assign idx            = addr[IW+1:2];
    assign unused_addr_hi = ^addr[31:IW+2];

    assign req = mem_read ^ mem_write;
    assign bad = (mem_read & mem_write) | ((mem_read | mem_write) & (addr[1:0] != 2'b00));

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bad) begin
                    err = 1'b1;
                end else if (req) begin
                    stall     = 1'b1;
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    stall = 1'b1;
                end else begin
                    done      = 1'b1;
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, latency counter, load result and error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            store_q   <= 1'b0;
            read_data <= '0;
            err_count <= '0;
        end else begin
            if (err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (accept) begin
                idx_q   <= idx;
                data_q  <= write_data;
                store_q <= mem_write;
                cnt     <= CW'(LATENCY - 1);
                if (mem_read) begin
                    read_data <= mem[idx];
                end
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Stores commit on the completion edge; an aborted access never reaches it.
    always_ff @(posedge clk) begin
        if (commit && store_q) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule
